// File: rtl/jhash_head_if.sv
// rtl/jhash_head_if.sv - hash-in / candidate-out handshake bundle for jhash_head
interface jhash_head_if #(
    parameter int PW = 16
);
    logic [31:0]   hash_out;
    logic          hash_done;
    logic          new_stream;
    logic          hh_ready;
    logic          cand_valid;
    logic          cand_ready;
    logic          cand_hit;
    logic [PW-1:0] cand_pos;
    logic [PW-1:0] cur_pos;
    logic          ovf;

    modport master (
        output hash_out, hash_done, new_stream, cand_ready,
        input  hh_ready, cand_valid, cand_hit, cand_pos, cur_pos, ovf
    );

    modport slave (
        input  hash_out, hash_done, new_stream, cand_ready,
        output hh_ready, cand_valid, cand_hit, cand_pos, cur_pos, ovf
    );
endinterface

// File: rtl/jhash_head.sv
// rtl/jhash_head.sv - hash-head table returning the previous position per bucket
// Optional JHASH_HEAD_FOLD_EN: fold all hash bits into the bucket index instead of truncating.
module jhash_head #(
    parameter int AW = 10,
    parameter int PW = 16
) (
    input  logic        clk,
    input  logic        rst,
    jhash_head_if.slave bus
);
    typedef enum logic [2:0] {CLR, IDLE, RD, WR, OUT} state_t;

    state_t        state;
    logic [AW-1:0] clr_addr;
    logic [AW-1:0] idx;
    logic [PW-1:0] pos_cnt;
    logic [PW-1:0] cur_pos_r;
    logic [PW-1:0] cand_pos_r;
    logic          cand_hit_r;
    logic          cand_valid_r;
    logic          hh_ready_r;
    logic          ovf_r;

    logic [PW:0]   mem [0:(2**AW)-1];
    logic [PW:0]   rd_data;
    logic          we;
    logic [AW-1:0] waddr;
    logic [PW:0]   wdata;
    logic [AW-1:0] hash_idx;

`ifdef JHASH_HEAD_FOLD_EN
    // Bit i of the hash lands on index bit i mod AW: XOR of AW-wide slices, top slice zero-extended.
    always_comb begin
        hash_idx = '0;
        for (int i = 0; i < 32; i++) begin
            hash_idx[i % AW] = hash_idx[i % AW] ^ bus.hash_out[i];
        end
    end
`else
    logic unused_hash_bits;
    assign hash_idx         = bus.hash_out[AW-1:0];
    assign unused_hash_bits = ^bus.hash_out[31:AW];
`endif

    always_comb begin
        we    = 1'b0;
        waddr = idx;
        wdata = {1'b1, cur_pos_r};
        if (state == CLR) begin
            we    = 1'b1;
            waddr = clr_addr;
            wdata = '0;
        end else if (state == WR) begin
            we    = 1'b1;
        end
    end

    // Read every cycle at idx; only the value captured at the end of RD is consumed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rd_data <= mem[idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= CLR;
            clr_addr     <= '0;
            idx          <= '0;
            pos_cnt      <= '0;
            cur_pos_r    <= '0;
            cand_pos_r   <= '0;
            cand_hit_r   <= 1'b0;
            cand_valid_r <= 1'b0;
            hh_ready_r   <= 1'b0;
            ovf_r        <= 1'b0;
        end else if (bus.new_stream) begin
            state        <= CLR;
            clr_addr     <= '0;
            pos_cnt      <= '0;
            cand_valid_r <= 1'b0;
            hh_ready_r   <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            if (bus.hash_done && !hh_ready_r) begin
                ovf_r <= 1'b1;
            end
            case (state)
                CLR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == {AW{1'b1}}) begin
                        state      <= IDLE;
                        hh_ready_r <= 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.hash_done) begin
                        idx        <= hash_idx;
                        cur_pos_r  <= pos_cnt;
                        pos_cnt    <= pos_cnt + 1'b1;
                        hh_ready_r <= 1'b0;
                        state      <= RD;
                    end
                end
                RD: begin
                    state <= WR;
                end
                WR: begin
                    cand_hit_r   <= rd_data[PW];
                    cand_pos_r   <= rd_data[PW] ? rd_data[PW-1:0] : '0;
                    cand_valid_r <= 1'b1;
                    state        <= OUT;
                end
                OUT: begin
                    if (bus.cand_ready) begin
                        cand_valid_r <= 1'b0;
                        hh_ready_r   <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state      <= CLR;
                    clr_addr   <= '0;
                    hh_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hh_ready   = hh_ready_r;
    assign bus.cand_valid = cand_valid_r;
    assign bus.cand_hit   = cand_hit_r;
    assign bus.cand_pos   = cand_pos_r;
    assign bus.cur_pos    = cur_pos_r;
    assign bus.ovf        = ovf_r;
endmodule

// File: tb/tb_jhash_head.sv
// tb/tb_jhash_head.sv - directed and randomized bench for jhash_head against a bucket-table model
module tb_jhash_head;
    logic clk = 1'b0;
    logic rst = 1'b1;

    jhash_head_if #(.PW(16)) bus ();

    jhash_head #(.AW(10), .PW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    bit mvalid [1024];
    int mpos   [1024];
    int mcnt;
    bit exp_ovf;
    int pool   [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bucket(input logic [31:0] h);
`ifdef JHASH_HEAD_FOLD_EN
        return int'((h ^ (h >> 10) ^ (h >> 20) ^ (h >> 30)) & 32'h3ff);
`else
        return int'(h % 1024);
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) begin
            mvalid[i] = 1'b0;
            mpos[i]   = 0;
        end
        mcnt    = 0;
        exp_ovf = 1'b0;
    endtask

    task automatic count_clear(input string tag);
        int n;
        n = 0;
        while (!bus.hh_ready && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, n, 1024);
    endtask

    // One hash through the block; optional stall in OUT, a dropped pulse, or a new_stream abort.
    task automatic send_hash(input logic [31:0] h, input int stall, input bit drop, input bit abort);
        int  lat, b, e_pos, e_cur;
        bit  e_hit;
        chk("hh_ready_pre", bus.hh_ready, 1'b1);
        b     = bucket(h);
        e_hit = mvalid[b];
        e_pos = e_hit ? mpos[b] : 0;
        e_cur = mcnt;
        mvalid[b] = 1'b1;
        mpos[b]   = mcnt;
        mcnt      = (mcnt + 1) % 65536;
        bus.hash_out  = h;
        bus.hash_done = 1'b1;
        tick();
        bus.hash_done = 1'b0;
        lat = 0;
        while (!bus.cand_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("latency", lat, 2);
        chk("cand_hit", bus.cand_hit, e_hit);
        chk("cand_pos", bus.cand_pos, e_pos);
        chk("cur_pos", bus.cur_pos, e_cur);
        for (int s = 0; s < stall; s++) begin
            if (drop && s == 0) begin
                bus.hash_out  = $urandom;
                bus.hash_done = 1'b1;
                exp_ovf       = 1'b1;
            end
            tick();
            bus.hash_done = 1'b0;
            chk("stall_valid", bus.cand_valid, 1'b1);
            chk("stall_cur_pos", bus.cur_pos, e_cur);
            chk("stall_ovf", bus.ovf, exp_ovf);
        end
        if (abort) begin
            bus.new_stream = 1'b1;
            bus.hash_done  = 1'b1;
            bus.hash_out   = 32'h0000_0123;
            tick();
            bus.new_stream = 1'b0;
            bus.hash_done  = 1'b0;
            model_clear();
            chk("abort_valid", bus.cand_valid, 1'b0);
            chk("abort_ovf", bus.ovf, 1'b0);
            chk("abort_hh_ready", bus.hh_ready, 1'b0);
        end else begin
            bus.cand_ready = 1'b1;
            tick();
            bus.cand_ready = 1'b0;
            chk("accept_valid", bus.cand_valid, 1'b0);
            chk("accept_hh_ready", bus.hh_ready, 1'b1);
            chk("ovf", bus.ovf, exp_ovf);
        end
    endtask

    initial begin
        bus.hash_out   = '0;
        bus.hash_done  = 1'b0;
        bus.new_stream = 1'b0;
        bus.cand_ready = 1'b0;
        model_clear();
        for (int i = 0; i < 8; i++) pool[i] = $urandom;
        repeat (3) tick();
        chk("rst_hh_ready", bus.hh_ready, 1'b0);
        chk("rst_cand_valid", bus.cand_valid, 1'b0);
        chk("rst_cand_hit", bus.cand_hit, 1'b0);
        chk("rst_cand_pos", bus.cand_pos, 16'h0);
        chk("rst_cur_pos", bus.cur_pos, 16'h0);
        chk("rst_ovf", bus.ovf, 1'b0);
        rst = 1'b0;
        count_clear("clear_cycles");
        chk("clear_ovf", bus.ovf, 1'b0);

        send_hash(32'h0000_0123, 0, 1'b0, 1'b0);
        send_hash(32'h0000_0123, 0, 1'b0, 1'b0);
        send_hash(32'h0000_0456, 0, 1'b0, 1'b0);
        send_hash(32'h0040_0123, 0, 1'b0, 1'b0);
        send_hash(32'h0000_0789, 3, 1'b1, 1'b0);
        send_hash(32'h0000_0abc, 1, 1'b0, 1'b0);
        send_hash(32'h0000_0789, 2, 1'b0, 1'b1);
        count_clear("reclear_cycles");
        send_hash(32'h0000_0123, 0, 1'b0, 1'b0);

        for (int k = 0; k < 120; k++) begin
            logic [31:0] h;
            int st;
            h  = ($urandom_range(0, 2) == 0) ? $urandom : pool[$urandom_range(0, 7)];
            st = $urandom_range(0, 3);
            send_hash(h, st, (st > 0) && ($urandom_range(0, 3) == 0), 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
